// File: rtl/spi_master_fifo_wm.sv
// First-word-fall-through FIFO for the SPI master datapath with programmable
// almost-full/almost-empty watermarks and sticky overflow/underflow flags.
module spi_master_fifo_wm #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 8,
    localparam int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        status_clr_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic                        ready_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    input  logic [LOG_BUFFER_DEPTH:0]   almost_full_thr_i,
    input  logic [LOG_BUFFER_DEPTH:0]   almost_empty_thr_i,
    output logic                        almost_full_o,
    output logic                        almost_empty_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;
    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
    localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_ONE  = LOG_BUFFER_DEPTH'(1);
    localparam logic [CNT_W-1:0]            FULL_CNT = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0]            CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0]       mem_d [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        // A write while full is dropped even if a read frees a slot this cycle.
        push  = valid_i && !full;
        pop   = ready_i && !empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Setting beats a same-cycle status clear so no event is ever lost.
        if (valid_i && full) begin
            overflow_d = 1'b1;
        end else if (status_clr_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (ready_i && empty) begin
            underflow_d = 1'b1;
        end else if (status_clr_i) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign ready_o        = (count_q != FULL_CNT);
    assign valid_o        = (count_q != '0);
    assign data_o         = mem_q[rd_ptr_q];
    assign elements_o     = count_q;
    assign almost_full_o  = (count_q >= almost_full_thr_i);
    assign almost_empty_o = (count_q <= almost_empty_thr_i);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_spi_master_fifo_wm.sv
// Self-checking bench for spi_master_fifo_wm: fixed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_spi_master_fifo_wm;

   localparam int DW    = 8;
   localparam int DEPTH = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clr_i;
   logic          status_clr_i;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          ready_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
   logic [CW-1:0] elements_o;
   logic [CW-1:0] almost_full_thr_i;
   logic [CW-1:0] almost_empty_thr_i;
   logic          almost_full_o;
   logic          almost_empty_o;
   logic          overflow_o;
   logic          underflow_o;

   spi_master_fifo_wm #(
      .DATA_WIDTH  (DW),
      .BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .clr_i             (clr_i),
      .status_clr_i      (status_clr_i),
      .valid_i           (valid_i),
      .data_i            (data_i),
      .ready_o           (ready_o),
      .data_o            (data_o),
      .valid_o           (valid_o),
      .ready_i           (ready_i),
      .elements_o        (elements_o),
      .almost_full_thr_i (almost_full_thr_i),
      .almost_empty_thr_i(almost_empty_thr_i),
      .almost_full_o     (almost_full_o),
      .almost_empty_o    (almost_empty_o),
      .overflow_o        (overflow_o),
      .underflow_o       (underflow_o)
   );

   // Free-running clock, rising edge every 10 time units starting at t=5.
   always #5 clk_i = ~clk_i;

   // Reference model state: the FIFO contents as a plain queue plus the two sticky flags.
   logic [DW-1:0] modelQ[$];
   logic          modelOvf;
   logic          modelUnf;
   int            checks = 0;
   int            errors = 0;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          r;
      logic [CW-1:0] el;
      logic          rdy;
      logic          vld;
      logic [DW-1:0] dat;
      logic          af;
      logic          ae;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t tbl[7];

   // Single comparison point; every check in the bench goes through here.
   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Advances the model by one clock edge using the rules of the FIFO, not its structure.
   task automatic modelStep(input logic v, input logic [DW-1:0] d, input logic r,
                            input logic c, input logic s);
      int  n;
      bit  isFull;
      bit  isEmpty;
      n       = modelQ.size();
      isFull  = (n == DEPTH);
      isEmpty = (n == 0);
      if (v && isFull) modelOvf = 1'b1;
      else if (s)      modelOvf = 1'b0;
      if (r && isEmpty) modelUnf = 1'b1;
      else if (s)       modelUnf = 1'b0;
      if (c) begin
         modelQ.delete();
      end else begin
         if (r && !isEmpty) void'(modelQ.pop_front());
         if (v && !isFull) modelQ.push_back(d);
      end
   endtask

   // Drives one cycle of inputs, takes the rising edge, updates the model and settles.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                                input logic c, input logic s);
      valid_i      = v;
      data_i       = d;
      ready_i      = r;
      clr_i        = c;
      status_clr_i = s;
      @(posedge clk_i);
      modelStep(v, d, r, c, s);
      #1;
   endtask

   // Compares every output against the model, sampled 1 unit after the edge.
   task automatic checkOutput(input string tag);
      int n;
      n = modelQ.size();
      compare({tag, ".elements"}, 32'(elements_o), 32'(n));
      compare({tag, ".valid"}, 32'(valid_o), 32'(n != 0));
      compare({tag, ".ready"}, 32'(ready_o), 32'(n != DEPTH));
      if (n != 0) compare({tag, ".data"}, 32'(data_o), 32'(modelQ[0]));
      compare({tag, ".almostFull"}, 32'(almost_full_o), 32'(n >= int'(almost_full_thr_i)));
      compare({tag, ".almostEmpty"}, 32'(almost_empty_o), 32'(n <= int'(almost_empty_thr_i)));
      compare({tag, ".overflow"}, 32'(overflow_o), 32'(modelOvf));
      compare({tag, ".underflow"}, 32'(underflow_o), 32'(modelUnf));
   endtask

   task automatic checkResetValues(input string tag);
      compare({tag, ".elements"}, 32'(elements_o), 32'd0);
      compare({tag, ".valid"}, 32'(valid_o), 32'd0);
      compare({tag, ".ready"}, 32'(ready_o), 32'd1);
      compare({tag, ".data"}, 32'(data_o), 32'd0);
      compare({tag, ".almostFull"}, 32'(almost_full_o), 32'(almost_full_thr_i == '0));
      compare({tag, ".almostEmpty"}, 32'(almost_empty_o), 32'd1);
      compare({tag, ".overflow"}, 32'(overflow_o), 32'd0);
      compare({tag, ".underflow"}, 32'(underflow_o), 32'd0);
   endtask

   initial begin
      // Fill 0 -> 5 with thresholds af=4 / ae=1, overflow on the sixth push, then one pop.
      tbl[0] = '{1'b1, 8'hA0, 1'b0, 4'd1, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'hA1, 1'b0, 4'd2, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 8'hA2, 1'b0, 4'd3, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'hA3, 1'b0, 4'd4, 1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 8'hA4, 1'b0, 4'd5, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'hA5, 1'b0, 4'd5, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 4'd4, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0};

      modelOvf           = 1'b0;
      modelUnf           = 1'b0;
      rst_ni             = 1'b0;
      clr_i              = 1'b0;
      status_clr_i       = 1'b0;
      valid_i            = 1'b0;
      data_i             = '0;
      ready_i            = 1'b0;
      almost_full_thr_i  = 4'd4;
      almost_empty_thr_i = 4'd1;
      #1;
      checkResetValues("reset");
      #12;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, 1'b0);
         compare($sformatf("vec%0d.elements", i), 32'(elements_o), 32'(tbl[i].el));
         compare($sformatf("vec%0d.ready", i), 32'(ready_o), 32'(tbl[i].rdy));
         compare($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(tbl[i].vld));
         compare($sformatf("vec%0d.data", i), 32'(data_o), 32'(tbl[i].dat));
         compare($sformatf("vec%0d.almostFull", i), 32'(almost_full_o), 32'(tbl[i].af));
         compare($sformatf("vec%0d.almostEmpty", i), 32'(almost_empty_o), 32'(tbl[i].ae));
         compare($sformatf("vec%0d.overflow", i), 32'(overflow_o), 32'(tbl[i].ovf));
         compare($sformatf("vec%0d.underflow", i), 32'(underflow_o), 32'(tbl[i].unf));
      end

      // Threshold changes take effect combinationally, with no clock edge (occupancy 4).
      almost_full_thr_i = 4'd6;
      #1 compare("thr.afAboveDepth", 32'(almost_full_o), 32'd0);
      almost_full_thr_i = 4'd4;
      #1 compare("thr.afAtCount", 32'(almost_full_o), 32'd1);
      almost_empty_thr_i = 4'd0;
      #1 compare("thr.aeZero", 32'(almost_empty_o), 32'd0);
      almost_empty_thr_i = 4'd4;
      #1 compare("thr.aeAtCount", 32'(almost_empty_o), 32'd1);
      almost_empty_thr_i = 4'd1;

      // Drain A1..A4 in order.
      for (int i = 0; i < 4; i++) begin
         compare($sformatf("drain%0d.head", i), 32'(data_o), 32'hA1 + 32'(i));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("drain");
      end

      // Status clear: empty read sets underflow, clear loses to a same-cycle set.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      compare("unf.set", 32'(underflow_o), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      compare("unf.setWinsClear", 32'(underflow_o), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      compare("unf.cleared", 32'(underflow_o), 32'd0);
      checkOutput("statusClr");

      // Flush with 3 queued; the write in the flush cycle is discarded.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      checkOutput("preFlush");
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      compare("flush.elements", 32'(elements_o), 32'd0);
      compare("flush.valid", 32'(valid_o), 32'd0);
      compare("flush.overflow", 32'(overflow_o), 32'd0);
      applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      compare("flush.firstWord", 32'(data_o), 32'h66);
      compare("flush.oneEntry", 32'(elements_o), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("flushPop");

      // Wrap: 12 words through a depth-5 FIFO, steady occupancy 2 while overlapping.
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      for (int i = 2; i < 12; i++) begin
         compare($sformatf("wrap%0d.head", i), 32'(data_o), 32'(i - 2));
         applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
         compare($sformatf("wrap%0d.count", i), 32'(elements_o), 32'd2);
         checkOutput("wrap");
      end
      for (int i = 10; i < 12; i++) begin
         compare($sformatf("wrapTail%0d.head", i), 32'(data_o), 32'(i));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("wrapTail");
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         almost_full_thr_i  = CW'($urandom_range(0, 7));
         almost_empty_thr_i = CW'($urandom_range(0, 7));
         applyStimulus(1'($urandom_range(0, 99) < 55), DW'($urandom),
                       1'($urandom_range(0, 99) < 45),
                       1'($urandom_range(0, 39) == 0),
                       1'($urandom_range(0, 11) == 0));
         checkOutput($sformatf("rand%0d", i));
      end

      // Async reset between edges with 4 entries queued.
      almost_full_thr_i  = 4'd0;
      almost_empty_thr_i = 4'd1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hC0 + DW'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("preReset");
      valid_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      checkResetValues("asyncReset");
      modelQ.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("postReset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
